// File: rtl/verinject_injection_sequencer.sv
// Injection sequencer: queues (cycle, bit) commands and broadcasts each bit index on
// its due cycle. Define VERINJECT_SEQ_LATE_DROP_EN to drop late commands instead of firing them.
module verinject_injection_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_cycle,
  input  logic [31:0] cmd_bit,
  input  logic        clear_req,
  output logic [31:0] verinject__injector_state,
  output logic [31:0] cycle_now,
  output logic        busy,
  output logic [15:0] inject_count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_FIRE  = 2'd2;
  localparam logic [1:0] ST_CLEAR = 2'd3;
  localparam logic [31:0] IDLE_VALUE  = 32'hFFFF_FFFF;
  localparam logic [31:0] CLEAR_VALUE = 32'hFFFF_FFFE;
  localparam logic [PW:0] DEPTH_CNT   = (PW+1)'(DEPTH);

  // The two reserved injector-state codes are never queued: they would collide with idle/clear.
  function automatic logic is_reserved(input logic [31:0] value);
    return (value[31:1] == 31'h7FFF_FFFF);
  endfunction

  logic [31:0] fifo_cycle_r [DEPTH];
  logic [31:0] fifo_bit_r   [DEPTH];
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [PW:0]   count_r;
  logic [PW:0]   count_next_s;
  logic [1:0]    state_r;
  logic [1:0]    state_s;
  logic [31:0]   cycle_r;
  logic [31:0]   cycle_next_s;
  logic [31:0]   out_r;
  logic [31:0]   out_s;
  logic [15:0]   inj_r;
  logic          accept_s;
  logic          push_s;
  logic          pop_s;
  logic          fire_s;
  logic          head_due_s;
`ifdef VERINJECT_SEQ_LATE_DROP_EN
  logic          head_late_s;
`endif

  assign cmd_ready                = (count_r != DEPTH_CNT);
  assign accept_s                 = cmd_valid && cmd_ready;
  assign push_s                   = accept_s && !is_reserved(cmd_bit);
  assign verinject__injector_state = out_r;
  assign cycle_now                = cycle_r;
  assign inject_count             = inj_r;
  assign busy                     = (state_r != ST_IDLE) || (count_r != {(PW+1){1'b0}}) || clear_req;

  // Decide what the next cycle drives; decisions look one cycle ahead so the output lands on cmd_cycle.
  always_comb begin
    cycle_next_s = (cycle_r == IDLE_VALUE) ? cycle_r : cycle_r + 32'd1;
    head_due_s   = (count_r != {(PW+1){1'b0}}) && (fifo_cycle_r[rd_ptr_r] <= cycle_next_s);
`ifdef VERINJECT_SEQ_LATE_DROP_EN
    head_late_s  = (fifo_cycle_r[rd_ptr_r] < cycle_next_s);
`endif
    pop_s  = 1'b0;
    fire_s = 1'b0;
    out_s  = IDLE_VALUE;
    if (clear_req) begin
      out_s = CLEAR_VALUE;
    end else if (head_due_s) begin
      pop_s = 1'b1;
`ifdef VERINJECT_SEQ_LATE_DROP_EN
      fire_s = !head_late_s;
`else
      fire_s = 1'b1;
`endif
      if (fire_s) begin
        out_s = fifo_bit_r[rd_ptr_r];
      end else begin
        out_s = IDLE_VALUE;
      end
    end else begin
      pop_s = 1'b0;
    end
    count_next_s = count_r + {{PW{1'b0}}, push_s} - {{PW{1'b0}}, pop_s};
    if (clear_req) begin
      state_s = ST_CLEAR;
    end else if (fire_s) begin
      state_s = ST_FIRE;
    end else if (count_next_s != {(PW+1){1'b0}}) begin
      state_s = ST_WAIT;
    end else begin
      state_s = ST_IDLE;
    end
  end

  // Command storage; pointers and count carry the validity, so the payload needs no reset.
  always_ff @(posedge clock) begin
    if (push_s) begin
      fifo_cycle_r[wr_ptr_r] <= cmd_cycle;
      fifo_bit_r[wr_ptr_r]   <= cmd_bit;
    end
  end

  // Sequencer state, queue pointers, counters and the broadcast register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {(PW+1){1'b0}};
      state_r  <= ST_IDLE;
      cycle_r  <= 32'd0;
      out_r    <= IDLE_VALUE;
      inj_r    <= 16'd0;
    end else begin
      cycle_r <= cycle_next_s;
      out_r   <= out_s;
      state_r <= state_s;
      count_r <= count_next_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
      end
      if (fire_s && (inj_r != 16'hFFFF)) begin
        inj_r <= inj_r + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_verinject_injection_sequencer.sv
// Scoreboard bench for verinject_injection_sequencer: expected broadcasts are queued as
// (cycle, value) pairs when commands are driven and matched whenever the output leaves idle.
module tb_verinject_injection_sequencer;

`ifdef VERINJECT_SEQ_LATE_DROP_EN
  localparam bit LATE_DROP = 1'b1;
`else
  localparam bit LATE_DROP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_cycle = 32'd0;
  logic [31:0] cmd_bit = 32'd0;
  logic        clear_req = 1'b0;
  logic [31:0] verinject__injector_state;
  logic [31:0] cycle_now;
  logic        busy;
  logic [15:0] inject_count;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [31:0] cyc;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  verinject_injection_sequencer #(.DEPTH(4)) dut (
    .clock(clock),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_cycle(cmd_cycle),
    .cmd_bit(cmd_bit),
    .clear_req(clear_req),
    .verinject__injector_state(verinject__injector_state),
    .cycle_now(cycle_now),
    .busy(busy),
    .inject_count(inject_count)
  );

  always #5 clock = ~clock;

  task automatic do_reset();
    reset = 1'b1;
    cmd_valid = 1'b0;
    clear_req = 1'b0;
    sb.delete();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (verinject__injector_state !== 32'hFFFF_FFFF) begin fails++; $display("FAIL reset_state: got %h want ffffffff", verinject__injector_state); end
    tests++; if (cycle_now !== 32'd0) begin fails++; $display("FAIL reset_cycle: got %0d want 0", cycle_now); end
    tests++; if (inject_count !== 16'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", inject_count); end
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_single();
    exp_t e;
    do_reset();
    cmd_valid = 1'b1; cmd_cycle = 32'd10; cmd_bit = 32'd5;
    sb.push_back('{cyc: 32'd10, val: 32'd5});
    @(negedge clock);
    cmd_valid = 1'b0;
    repeat (25) begin
      @(negedge clock);
      if (verinject__injector_state !== 32'hFFFF_FFFF) begin
        tests++;
        if (sb.size() == 0) begin
          fails++; $display("FAIL single_unexpected: got %h at cycle %0d want ffffffff", verinject__injector_state, cycle_now);
        end else begin
          e = sb.pop_front();
          if (cycle_now !== e.cyc || verinject__injector_state !== e.val) begin
            fails++; $display("FAIL single_fire: got %h at cycle %0d want %h at cycle %0d", verinject__injector_state, cycle_now, e.val, e.cyc);
          end
        end
      end
    end
    tests++; if (sb.size() != 0) begin fails++; $display("FAIL single_missing: %0d pending want 0", sb.size()); end
    tests++; if (inject_count !== 16'd1) begin fails++; $display("FAIL single_count: got %0d want 1", inject_count); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1; cmd_cycle = 32'd100; cmd_bit = 32'd11 + 32'(i);
      tests++;
      if (cmd_ready !== (i < 4)) begin fails++; $display("FAIL b2b_ready%0d: got %b want %b", i, cmd_ready, (i < 4)); end
      if (i < 4 && (!LATE_DROP || i == 0)) sb.push_back('{cyc: 32'd100 + 32'(i), val: 32'd11 + 32'(i)});
      @(negedge clock);
    end
    cmd_valid = 1'b0;
    repeat (110) begin
      @(negedge clock);
      if (verinject__injector_state !== 32'hFFFF_FFFF) begin
        tests++;
        if (sb.size() == 0) begin
          fails++; $display("FAIL b2b_unexpected: got %h at cycle %0d want ffffffff", verinject__injector_state, cycle_now);
        end else begin
          e = sb.pop_front();
          if (cycle_now !== e.cyc || verinject__injector_state !== e.val) begin
            fails++; $display("FAIL b2b_fire: got %h at cycle %0d want %h at cycle %0d", verinject__injector_state, cycle_now, e.val, e.cyc);
          end
        end
      end
    end
    tests++; if (sb.size() != 0) begin fails++; $display("FAIL b2b_missing: %0d pending want 0", sb.size()); end
    tests++; if (inject_count !== (LATE_DROP ? 16'd1 : 16'd4)) begin fails++; $display("FAIL b2b_count: got %0d want %0d", inject_count, LATE_DROP ? 1 : 4); end
  endtask

  task automatic test_clear();
    exp_t e;
    do_reset();
    cmd_valid = 1'b1; cmd_cycle = 32'd50; cmd_bit = 32'd7;
    sb.push_back('{cyc: 32'd50, val: 32'hFFFF_FFFE});
    if (!LATE_DROP) sb.push_back('{cyc: 32'd51, val: 32'd7});
    @(negedge clock);
    cmd_valid = 1'b0;
    repeat (60) begin
      clear_req = (cycle_now == 32'd49);
      @(negedge clock);
      if (verinject__injector_state !== 32'hFFFF_FFFF) begin
        tests++;
        if (sb.size() == 0) begin
          fails++; $display("FAIL clear_unexpected: got %h at cycle %0d want ffffffff", verinject__injector_state, cycle_now);
        end else begin
          e = sb.pop_front();
          if (cycle_now !== e.cyc || verinject__injector_state !== e.val) begin
            fails++; $display("FAIL clear_out: got %h at cycle %0d want %h at cycle %0d", verinject__injector_state, cycle_now, e.val, e.cyc);
          end
        end
      end
    end
    clear_req = 1'b0;
    tests++; if (sb.size() != 0) begin fails++; $display("FAIL clear_missing: %0d pending want 0", sb.size()); end
    tests++; if (inject_count !== (LATE_DROP ? 16'd0 : 16'd1)) begin fails++; $display("FAIL clear_count: got %0d want %0d", inject_count, LATE_DROP ? 0 : 1); end
  endtask

  task automatic test_discard();
    do_reset();
    cmd_valid = 1'b1; cmd_cycle = 32'd0; cmd_bit = 32'hFFFF_FFFE;
    @(negedge clock);
    cmd_valid = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL discard_busy: got %b want 0", busy); end
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL discard_ready: got %b want 1", cmd_ready); end
    repeat (8) begin
      @(negedge clock);
      tests++;
      if (verinject__injector_state !== 32'hFFFF_FFFF) begin fails++; $display("FAIL discard_out: got %h at cycle %0d want ffffffff", verinject__injector_state, cycle_now); end
    end
    tests++; if (inject_count !== 16'd0) begin fails++; $display("FAIL discard_count: got %0d want 0", inject_count); end
  endtask

  task automatic test_reset_mid_fire();
    bit hit = 1'b0;
    do_reset();
    cmd_valid = 1'b1; cmd_cycle = 32'd5; cmd_bit = 32'd3;
    @(negedge clock);
    cmd_cycle = 32'd20; cmd_bit = 32'd9;
    @(negedge clock);
    cmd_valid = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clock);
      if (verinject__injector_state !== 32'hFFFF_FFFF) hit = 1'b1;
    end
    tests++;
    if (!hit || verinject__injector_state !== 32'd3 || cycle_now !== 32'd5) begin
      fails++; $display("FAIL midfire_fire: got %h at cycle %0d want 00000003 at cycle 5", verinject__injector_state, cycle_now);
    end
    reset = 1'b1;
    #1;
    tests++; if (verinject__injector_state !== 32'hFFFF_FFFF) begin fails++; $display("FAIL midfire_out: got %h want ffffffff", verinject__injector_state); end
    tests++; if (cycle_now !== 32'd0) begin fails++; $display("FAIL midfire_cycle: got %0d want 0", cycle_now); end
    tests++; if (inject_count !== 16'd0) begin fails++; $display("FAIL midfire_count: got %0d want 0", inject_count); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midfire_busy: got %b want 0", busy); end
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL midfire_ready: got %b want 1", cmd_ready); end
    @(negedge clock);
    reset = 1'b0;
    repeat (30) begin
      @(negedge clock);
      tests++;
      if (verinject__injector_state !== 32'hFFFF_FFFF) begin fails++; $display("FAIL midfire_flush: got %h at cycle %0d want ffffffff", verinject__injector_state, cycle_now); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_clear();
    test_discard();
    test_reset_mid_fire();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/verinject_injection_sequencer.md
VERINJECT_INJECTION_SEQUENCER -- requirements
Module: verinject_injection_sequencer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of pending injection command slots (power of two, 2..16).
REQ-002 The block SHALL have port clock  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port cmd_valid  input  1  an injection command is offered.
REQ-005 The block SHALL have port cmd_ready  output  1  a command can be accepted this cycle.
REQ-006 The block SHALL have port cmd_cycle  input  32  the cycle number at which to inject.
REQ-007 The block SHALL have port cmd_bit  input  32  the injector-state value to drive, i.e. the global bit index.
REQ-008 The block SHALL have port clear_req  input  1  a one-cycle pulse requesting an injector buffer reset.
REQ-009 The block SHALL have port verinject__injector_state  output  32  the value broadcast to all injectors.
REQ-010 The block SHALL have port cycle_now  output  32  the free-running cycle counter.
REQ-011 The block SHALL have port busy  output  1  high when the queue is non-empty or an action is in flight.
REQ-012 The block SHALL have port inject_count  output  16  the number of injections fired, saturating at 0xFFFF.

Function
REQ-013 The block SHALL accept a command on a rising edge where cmd_valid && cmd_ready, and SHALL store it in FIFO order.
REQ-014 cmd_ready SHALL be low exactly when DEPTH commands are pending; a command offered while cmd_ready is low SHALL be ignored.
REQ-015 A command with cmd_bit of 0xFFFF_FFFE or 0xFFFF_FFFF SHALL be accepted and discarded without firing and without being counted.
REQ-016 cycle_now SHALL increment by 1 every cycle from 0 after reset and SHALL saturate at 0xFFFF_FFFF.
REQ-017 The idle value of verinject__injector_state SHALL be 0xFFFF_FFFF.
REQ-018 The state machine SHALL have the states IDLE (queue empty), WAIT (head pending, head cmd_cycle > cycle_now), FIRE (driving cmd_bit for one cycle) and CLEAR (driving 0xFFFF_FFFE for one cycle).
REQ-019 verinject__injector_state SHALL equal the head cmd_bit during exactly the one cycle in which cycle_now == cmd_cycle; that head SHALL then be popped and inject_count SHALL increment.
REQ-020 A head whose cmd_cycle < cycle_now (late) SHALL fire in the first cycle it is eligible, subject to REQ-028.
REQ-021 At most one command SHALL fire per cycle; commands sharing the same cmd_cycle SHALL fire in consecutive cycles in FIFO order.
REQ-022 A clear_req pulse SHALL produce 0xFFFF_FFFE on verinject__injector_state in the following cycle.
REQ-023 clear_req SHALL take priority over a due injection, which SHALL be deferred by one cycle and then treated as late.
REQ-024 clear_req SHALL NOT flush the queue.
REQ-025 A command accepted in the cycle it becomes due SHALL be treated as late.
REQ-026 busy SHALL be low only in IDLE with no clear pending.

Reset
REQ-027 Asserting reset SHALL immediately, without waiting for a clock edge, set the following, including in the middle of FIRE or CLEAR:
- queue emptied
- state IDLE
- verinject__injector_state 0xFFFF_FFFF
- cycle_now 0
- inject_count 0
- cmd_ready 1
- busy 0

Configuration
REQ-028 When VERINJECT_SEQ_LATE_DROP_EN is defined, late commands (REQ-020, REQ-023, REQ-025) SHALL be popped without firing and without incrementing inject_count. When the macro is undefined, late commands SHALL fire as described in REQ-020.

Verification
REQ-029 The bench SHALL cover: reset release, then command (cycle 10, bit 5) -> verinject__injector_state == 5 only while cycle_now == 10, 0xFFFF_FFFF otherwise, and inject_count == 1.
REQ-030 The bench SHALL cover: DEPTH=4, five back-to-back commands at cycle 100 -> cmd_ready low after the fourth; bits fire at cycle_now 100..103 in order.
REQ-031 The bench SHALL cover: clear_req at cycle 49 with command (50, 7) -> 0xFFFF_FFFE at cycle 50; bit 7 fires at cycle 51, or is dropped and inject_count stays 0 with VERINJECT_SEQ_LATE_DROP_EN.
REQ-032 The bench SHALL cover: command (cycle 0, bit 0xFFFF_FFFE) -> no output change, inject_count 0, queue empty next cycle.
REQ-033 The bench SHALL cover: reset asserted during FIRE of bit 3 -> output 0xFFFF_FFFF immediately and the queue empty.
